// File: rtl/qe_pkg.sv
// Shared widths and FSM encoding for the QE_M result serializer.
package qe_pkg;
    localparam int RESULT_W = 16;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;
endpackage

// File: rtl/qe_result_serializer_if.sv
// Result-in / byte-out bus between QE_M, the serializer and the byte consumer.
interface qe_result_serializer_if;
    import qe_pkg::*;

    logic                in_valid;
    logic [RESULT_W-1:0] in_result;
    logic                out_valid;
    logic                out_ready;
    logic [BYTE_W-1:0]   out_data;
    logic                out_first;

    // master: the surrounding system (producer and consumer); slave: the serializer
    modport master (output in_valid, in_result, out_ready,
                    input  out_valid, out_data, out_first);
    modport slave  (input  in_valid, in_result, out_ready,
                    output out_valid, out_data, out_first);
endinterface

// File: rtl/qe_sync_fifo.sv
// Single-clock FIFO with a count-based full flag and a combinational head read.
module qe_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/qe_result_serializer.sv
// Buffers QE_M results and streams each one as two bytes, MSB first, with drop-on-full.
module qe_result_serializer
    import qe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    qe_result_serializer_if.slave  bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_ovf
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t              state;
    logic [RESULT_W-1:0] head;
    logic                full;
    logic                empty;
    logic                pop;
    logic                accept;
    logic                more;
    logic                valid_q;
    logic                first_q;
    logic [BYTE_W-1:0]   byte_d;

    // A full FIFO still accepts when the head leaves on the same edge.
    assign pop    = (state == ST_LO) && bus.out_ready;
    assign accept = bus.in_valid && (!full || pop);
    assign more   = (count > CW'(1)) || accept;

    qe_sync_fifo #(.DEPTH(DEPTH), .W(RESULT_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata (bus.in_result),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus.in_valid && !accept) overflow <= 1'b1;
            else if (clr_ovf)            overflow <= 1'b0;

            case (state)
                ST_IDLE: if (!empty) begin
                    state   <= ST_HI;
                    valid_q <= 1'b1;
                    first_q <= 1'b1;
                end
                ST_HI: if (bus.out_ready) begin
                    state   <= ST_LO;
                    first_q <= 1'b0;
                end
                ST_LO: if (bus.out_ready) begin
                    if (more) begin
                        state   <= ST_HI;
                        first_q <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    // The head only moves on an LSB transfer, so the byte is stable under backpressure.
    always_comb begin
        byte_d = '0;
        case (state)
            ST_HI:   byte_d = head[RESULT_W-1:BYTE_W];
            ST_LO:   byte_d = head[BYTE_W-1:0];
            default: byte_d = '0;
        endcase
    end

    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_data  = byte_d;
endmodule

// File: tb/tb_qe_result_serializer.sv
// Bench for qe_result_serializer: fixed vector table, directed corner sequences, random run vs queue model.
module tb_qe_result_serializer;
    import qe_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] count;
    logic       overflow;

    qe_result_serializer_if bus();

    qe_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: queue of accepted results, which half of the head is due, sticky flag.
    logic [15:0] mq[$];
    bit          half = 1'b0;
    bit          ovf_m = 1'b0;
    bit          prev_valid = 1'b0;
    int          idle_wait = 0;
    logic [15:0] last_pop = '0;

    typedef struct {
        logic        iv;
        logic [15:0] ir;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        ef;
        logic [3:0]  ec;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic drive(input logic iv, input logic [15:0] ir, input logic rdy, input logic clr);
        bus.in_valid  = iv;
        bus.in_result = ir;
        bus.out_ready = rdy;
        clr_ovf       = clr;
    endtask

    task automatic model_clear();
        mq.delete();
        half       = 1'b0;
        ovf_m      = 1'b0;
        prev_valid = 1'b0;
        idle_wait  = 0;
    endtask

    // One clock: drive, check outputs against the model at negedge, advance the model.
    task automatic step(input logic iv, input logic [15:0] ir, input logic rdy, input logic clr);
        bit xfer, pop, acc;
        drive(iv, ir, rdy, clr);
        @(negedge clk);
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (mq.size() == 0) begin
            chk("valid_when_empty", 32'(bus.out_valid), 32'd0);
            idle_wait = 0;
        end else if (bus.out_valid) begin
            chk("data", 32'(bus.out_data), half ? 32'(mq[0][7:0]) : 32'(mq[0][15:8]));
            chk("first", 32'(bus.out_first), 32'(!half));
            idle_wait = 0;
        end else begin
            idle_wait++;
            if (prev_valid) chk("no_gap", 32'(bus.out_valid), 32'd1);
            if (idle_wait > 1) chk("start_latency", 32'(bus.out_valid), 32'd1);
        end
        xfer = bus.out_valid && rdy && (mq.size() != 0);
        pop  = xfer && half;
        acc  = iv && ((mq.size() < DEPTH) || pop);
        if (xfer) begin
            if (half) begin
                last_pop = mq.pop_front();
                half = 1'b0;
            end else begin
                half = 1'b1;
            end
        end
        if (acc) mq.push_back(ir);
        if (iv && !acc) ovf_m = 1'b1;
        else if (clr)   ovf_m = 1'b0;
        prev_valid = bus.out_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (40) step(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        drive(1'b0, 16'h0, 1'b0, 1'b0);

        // Single result then back-to-back pair, out_ready held high; outputs are pre-edge.
        vt[0]  = '{1'b1, 16'h1941, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
        vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h19, 1'b1, 4'd1};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h41, 1'b0, 4'd1};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
        vt[5]  = '{1'b1, 16'h0320, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};
        vt[6]  = '{1'b1, 16'h0322, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1};
        vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h03, 1'b1, 4'd2};
        vt[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h20, 1'b0, 4'd2};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h03, 1'b1, 4'd1};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h22, 1'b0, 4'd1};
        vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0};

        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_first", 32'(bus.out_first), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].iv, vt[i].ir, vt[i].rdy, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {19'd0, bus.out_valid, bus.out_data, bus.out_first, count},
                {19'd0, vt[i].ev, vt[i].ed, vt[i].ef, vt[i].ec});
            @(posedge clk);
            #1;
        end
        model_clear();

        // Backpressure: MSB byte must hold for several stalled cycles.
        step(1'b1, 16'h1941, 1'b0, 1'b0);
        repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("bp_hold_data", 32'(bus.out_data), 32'h19);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        drain();
        chk("bp_last", 32'(last_pop), 32'h1941);

        // Overflow: nine pushes into eight entries, ninth dropped.
        for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain();
        chk("ovf_last", 32'(last_pop), 32'd8);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Full FIFO, push lands on the LSB-transfer edge.
        for (int i = 1; i <= 8; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b1, 16'hABCD, 1'b1, 1'b0);
        chk("full_pop_count", 32'(count), 32'd8);
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        drain();
        chk("full_pop_last", 32'(last_pop), 32'hABCD);

        // Reset mid-frame after the MSB byte of the first of three entries transfers.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h2200 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_first", 32'(bus.out_first), 32'd0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b1, 16'h5A5A, 1'b1, 1'b0);
        drain();
        chk("post_rst_last", 32'(last_pop), 32'h5A5A);

        // Random traffic with heavy enough input rate to hit full and drop.
        repeat (3000)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0));
        drain();
        chk("rand_drained", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
